ex_issue_stage: RTL

EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

---
 rtl/ex_issue_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ex_issue_stage.sv
// Execute issue stage: dispatches one request per entry to multi-cycle units,
// detects misaligned accesses and registers the entry toward the next stage.
module ex_issue_stage #(
  parameter int DW = 64,
  parameter int NU = 2,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_payload,
  input  logic [NU-1:0] in_unit_sel,
  input  logic          in_mem,
  input  logic [1:0]    in_size,
  input  logic [31:0]   in_addr,
  input  logic          in_exc,
  input  logic [5:0]    in_ecode,
  input  logic          in_ertn,
  input  logic          next_flush,
  input  logic          flush,
  output logic [NU-1:0] unit_req_valid,
  input  logic [NU-1:0] unit_req_ready,
  output logic          this_flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_payload,
  output logic          out_exc,
  output logic [5:0]    out_ecode,
  output logic [31:0]   out_badv,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [5:0] ECODE_ALE = 6'h09;

  logic          r_issued;
  logic          r_out_valid;
  logic [DW-1:0] r_out_payload;
  logic          r_out_exc;
  logic [5:0]    r_out_ecode;
  logic [31:0]   r_out_badv;
  logic [CW-1:0] r_stall_cnt;

  logic          w_ale;
  logic          w_this_flush;
  logic          w_req_ok;
  logic          w_hs;
  logic          w_ready_go;
  logic          w_adv;
  logic          w_stall;
  logic          w_cnt_sat;

  // Size code 3 is handled like a word access.
  assign w_ale = in_mem & (((in_size == 2'd1) & in_addr[0]) |
                           (in_size[1] & (in_addr[1:0] != 2'b00)));

  assign w_this_flush = in_valid & (in_exc | w_ale | in_ertn | next_flush);

  assign w_req_ok       = in_valid & ~r_issued & ~w_this_flush & ~flush;
  assign unit_req_valid = in_unit_sel & {NU{w_req_ok}};
  assign w_hs           = |(unit_req_valid & unit_req_ready);

  assign w_ready_go = ~in_valid | w_this_flush | (in_unit_sel == '0) | r_issued | w_hs;
  assign w_adv      = in_valid & w_ready_go & out_ready;
  assign w_stall    = in_valid & ~w_ready_go;
  assign w_cnt_sat  = (r_stall_cnt == {CW{1'b1}});

  assign in_ready   = ~rst & (~in_valid | (w_ready_go & out_ready));
  assign this_flush = w_this_flush;

  // Issue tracking: advance clears in the same cycle as a late handshake,
  // since the entry leaves the stage at that edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_issued <= 1'b0;
    end else if (w_adv) begin
      r_issued <= 1'b0;
    end else if (w_hs) begin
      r_issued <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_out_valid <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= in_valid & w_ready_go;
    end
  end

  // Output register stage: loads only when the entry advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_payload <= '0;
      r_out_exc     <= 1'b0;
      r_out_ecode   <= 6'h00;
      r_out_badv    <= 32'h0;
    end else if (w_adv) begin
      r_out_payload <= in_payload;
      r_out_exc     <= in_exc | w_ale;
      r_out_ecode   <= in_exc ? in_ecode : (w_ale ? ECODE_ALE : 6'h00);
      r_out_badv    <= in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_payload = r_out_payload;
  assign out_exc     = r_out_exc;
  assign out_ecode   = r_out_ecode;
  assign out_badv    = r_out_badv;
  assign stall_cnt   = r_stall_cnt;

endmodule
